pin_keypad_collector: RTL and testbench
=======================================

# pin_keypad_collector

Front-end stage feeding the parking access controller's `try_psswrd`/`psswrd_atmpt` inputs. It takes single-cycle key strobes from the gate keypad decoder and accumulates up to three decimal digits into an 8-bit PIN. On ENTER it presents the PIN with a one-cycle `try_psswrd` pulse. It also discards stale or invalid entries (clear key, inactivity timeout, value >255) and holds off further keys briefly after each submission so the controller can act on it.

## Interface
- `MAX_DIGITS`, 3: maximum digits accepted per entry (1..3).
- `TIMEOUT_CYC`, 1000: idle cycles in COLLECT before the partial entry is discarded (16-bit counter).
- `HOLDOFF_CYC`, 4: cycles keys are ignored after a submission or error (≥1).
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `en` input 1: entry enable; low discards any partial entry and ignores keys.
- `key_valid` input 1: one-cycle strobe, one key per strobe.
- `key_code` input 4: 0–9 digit, 0xA CLEAR, 0xB ENTER, 0xC–0xF ignored.
- `psswrd_atmpt` output 8: submitted PIN, held until the next submission.
- `try_psswrd` output 1: one-cycle pulse, `psswrd_atmpt` valid in the same cycle.
- `entry_err` output 1: one-cycle pulse on overflow (>255) or timeout.
- `digit_cnt` output 2: digits currently accumulated.
- `busy` output 1: high in COLLECT or HOLDOFF.

## Operation
- States:
  - IDLE: `digit_cnt` = 0.
  - COLLECT: ≥1 digit held.
  - HOLDOFF: keys ignored.
- Accumulator: 10 bits, acc_next = acc*10 + digit. The maximum value 999 fits without wrap. Compare against 255 only at ENTER.
- IDLE:
  - A digit loads acc = digit, sets `digit_cnt` = 1, and moves to COLLECT.
  - ENTER and CLEAR are ignored; no pulse.
- COLLECT, digit key:
  - If `digit_cnt` < MAX_DIGITS, the digit is accumulated.
  - Otherwise the digit is dropped, with no error.
  - Either way, the idle counter reloads.
- COLLECT, CLEAR: acc = 0, `digit_cnt` = 0, go to IDLE, no pulse.
- COLLECT, ENTER:
  - If acc ≤ 255: `psswrd_atmpt` ← acc[7:0] and `try_psswrd` pulses.
  - Else: `entry_err` pulses and `psswrd_atmpt` is unchanged.
  - Both cases clear acc and `digit_cnt` and go to HOLDOFF.
- COLLECT, timeout: after TIMEOUT_CYC consecutive cycles without an accepted key, `entry_err` pulses, acc is cleared, and the block goes to IDLE.
- HOLDOFF: all keys ignored for HOLDOFF_CYC cycles, then IDLE.
- `en` low:
  - From any state, go to IDLE, clear acc and `digit_cnt`, suppress pulses.
  - `psswrd_atmpt` keeps its value.
- Codes 0xC–0xF are ignored in every state and do not reload the idle counter.

## Timing
- Reset values: state IDLE, `psswrd_atmpt` 8'h00, `try_psswrd` 0, `entry_err` 0, `digit_cnt` 0, `busy` 0, acc 0, counters 0.
- Latency: an ENTER strobe sampled at edge N gives `try_psswrd`/`entry_err` high for exactly cycle N+1. `psswrd_atmpt` is updated at the same edge.
- Keys are accepted back-to-back, one per cycle. A digit at edge N is reflected in `digit_cnt` after edge N.
- Simultaneous accepted key and timeout expiry in one cycle: the key wins, the counter reloads, and no error is raised.
- `en` low in the same cycle as ENTER: `en` wins, no pulse.
- `rst` mid-entry or mid-HOLDOFF returns every output to its reset value at the next edge.
- After a pulse, HOLDOFF occupies cycles N+1 .. N+HOLDOFF_CYC. The first key accepted in IDLE is at edge N+HOLDOFF_CYC+1.

## Structure
- Shared package `parking_pkg` holds:
  - key code constants KEY_CLEAR = 4'hA and KEY_ENTER = 4'hB;
  - the `pin_state_t` enum (IDLE, COLLECT, HOLDOFF);
  - the PIN width (8).
- Sub-module `cycle_timer`: a loadable down-counter with a `load`/`expired` interface. It is instantiated twice, once for the timeout and once for holdoff.
- The rest of the block is a single registered FSM with the accumulator datapath.

## Test plan
- Keys 8, 7, ENTER on consecutive cycles → one-cycle `try_psswrd` with `psswrd_atmpt` = 8'h57 (87); `busy` high for 4 cycles of HOLDOFF.
- Keys 3, 0, 0, ENTER → `entry_err` pulse, no `try_psswrd`, `psswrd_atmpt` unchanged; 1, 2, 3, 4, ENTER → `psswrd_atmpt` = 123 (4th digit dropped).
- Keys 5, CLEAR, 9, ENTER → `psswrd_atmpt` = 9, one `try_psswrd`; ENTER alone in IDLE → no pulse.
- Key 4, then no keys for 1000 cycles → `entry_err` at the expiry cycle, `digit_cnt` = 0. A key arriving on the expiry cycle → no error.
- Key 8, `en` low for one cycle, 7, ENTER → `psswrd_atmpt` = 7. ENTER during HOLDOFF → ignored.
- `rst` asserted after keys 8, 7 → all outputs zero next cycle; then 8, 7, ENTER → normal 87 submission.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared definitions for the parking access front-end: key codes,
// PIN collector state encoding, PIN width and the decimal accumulator step.
package parking_pkg;

  localparam int       PIN_W     = 8;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [9:0] PIN_MAX   = 10'd255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLDOFF = 2'd2
  } pin_state_t;

  // acc*10 + digit; the caller guarantees acc <= 99, so the result is <= 999 and fits in 10 bits
  function automatic logic [9:0] acc_step(input logic [9:0] acc, input logic [3:0] digit);
    return (acc << 3) + (acc << 1) + {6'b0, digit};
  endfunction

endpackage

// File: rtl/pin_keypad_collector_if.sv
// Keypad-side and controller-side signals of the PIN collector.
// master: the keypad decoder / controller environment; slave: the collector.
interface pin_keypad_collector_if;
  import parking_pkg::*;

  logic             en;
  logic             key_valid;
  logic [3:0]       key_code;
  logic [PIN_W-1:0] psswrd_atmpt;
  logic             try_psswrd;
  logic             entry_err;
  logic [1:0]       digit_cnt;
  logic             busy;

  modport master (
    output en, key_valid, key_code,
    input  psswrd_atmpt, try_psswrd, entry_err, digit_cnt, busy
  );

  modport slave (
    input  en, key_valid, key_code,
    output psswrd_atmpt, try_psswrd, entry_err, digit_cnt, busy
  );

endinterface

// File: rtl/cycle_timer.sv
// Loadable 16-bit down-counter. o_expired is high during the last counted
// cycle, so a FSM acting on it changes state exactly LOAD_VAL edges after load.
module cycle_timer #(
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_expired
);

  localparam logic [15:0] LV = 16'(LOAD_VAL);

  logic [15:0] r_cnt;

  // Reload on request, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= 16'd0;
    else if (i_load)        r_cnt <= LV;
    else if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
  end

  assign o_expired = (r_cnt == 16'd1);

endmodule

// File: rtl/pin_keypad_collector.sv
// Collects up to MAX_DIGITS decimal key strobes into a PIN, submits it on
// ENTER with a one-cycle try_psswrd pulse, and rejects overflow/timeout
// entries with entry_err. Keys are ignored for HOLDOFF_CYC cycles after a submit.
module pin_keypad_collector
  import parking_pkg::*;
#(
  parameter int MAX_DIGITS  = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int HOLDOFF_CYC = 4
) (
  input logic                   clk,
  input logic                   rst,
  pin_keypad_collector_if.slave kp
);

  pin_state_t       r_state;
  logic [9:0]       r_acc;
  logic [1:0]       r_digit_cnt;
  logic [PIN_W-1:0] r_pin;
  logic             r_try;
  logic             r_err;
  logic             r_busy;

  logic w_is_digit;
  logic w_is_clear;
  logic w_is_enter;
  logic w_to_load;
  logic w_to_expired;
  logic w_ho_load;
  logic w_ho_expired;

  assign w_is_digit = kp.key_valid && (kp.key_code <= 4'd9);
  assign w_is_clear = kp.key_valid && (kp.key_code == KEY_CLEAR);
  assign w_is_enter = kp.key_valid && (kp.key_code == KEY_ENTER);

  // Any digit seen while entering (accepted or dropped) restarts the idle window
  assign w_to_load = kp.en && w_is_digit && (r_state == IDLE || r_state == COLLECT);
  // Holdoff starts on every ENTER taken in COLLECT, good PIN or not
  assign w_ho_load = kp.en && w_is_enter && (r_state == COLLECT);

  cycle_timer #(.LOAD_VAL(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_to_load),
    .o_expired(w_to_expired)
  );

  cycle_timer #(.LOAD_VAL(HOLDOFF_CYC)) u_holdoff (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_ho_load),
    .o_expired(w_ho_expired)
  );

  // Entry FSM with accumulator; priority is en low, then key, then timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= 10'd0;
      r_digit_cnt <= 2'd0;
      r_pin       <= '0;
      r_try       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_try <= 1'b0;
      r_err <= 1'b0;
      if (!kp.en) begin
        r_state     <= IDLE;
        r_acc       <= 10'd0;
        r_digit_cnt <= 2'd0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_is_digit) begin
              r_acc       <= {6'b0, kp.key_code};
              r_digit_cnt <= 2'd1;
              r_state     <= COLLECT;
              r_busy      <= 1'b1;
            end
          end
          COLLECT: begin
            if (w_is_digit) begin
              if (int'(r_digit_cnt) < MAX_DIGITS) begin
                r_acc       <= acc_step(r_acc, kp.key_code);
                r_digit_cnt <= r_digit_cnt + 2'd1;
              end
            end else if (w_is_clear) begin
              r_acc       <= 10'd0;
              r_digit_cnt <= 2'd0;
              r_state     <= IDLE;
              r_busy      <= 1'b0;
            end else if (w_is_enter) begin
              if (r_acc <= PIN_MAX) begin
                r_pin <= r_acc[PIN_W-1:0];
                r_try <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
              r_acc       <= 10'd0;
              r_digit_cnt <= 2'd0;
              r_state     <= HOLDOFF;
            end else if (w_to_expired) begin
              r_err       <= 1'b1;
              r_acc       <= 10'd0;
              r_digit_cnt <= 2'd0;
              r_state     <= IDLE;
              r_busy      <= 1'b0;
            end
          end
          HOLDOFF: begin
            if (w_ho_expired) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state     <= IDLE;
            r_acc       <= 10'd0;
            r_digit_cnt <= 2'd0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign kp.psswrd_atmpt = r_pin;
  assign kp.try_psswrd   = r_try;
  assign kp.entry_err    = r_err;
  assign kp.digit_cnt    = r_digit_cnt;
  assign kp.busy         = r_busy;

endmodule

// File: tb/tb_pin_keypad_collector.sv
// Directed bench for pin_keypad_collector: submission, overflow, digit drop,
// clear, timeout race, en override, holdoff and mid-entry reset.
module tb_pin_keypad_collector;
  import parking_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pin_keypad_collector_if kp();

  pin_keypad_collector #(
    .MAX_DIGITS (3),
    .TIMEOUT_CYC(1000),
    .HOLDOFF_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: present an optional key strobe, sample 1 time unit after the edge
  task automatic step(input logic v, input logic [3:0] c);
    kp.key_valid = v;
    kp.key_code  = c;
    @(posedge clk);
    #1;
    kp.key_valid = 1'b0;
    kp.key_code  = 4'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0);
  endtask

  initial begin
    kp.en        = 1'b1;
    kp.key_valid = 1'b0;
    kp.key_code  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pin",  32'(kp.psswrd_atmpt), 32'h00);
    chk("rst_try",  32'(kp.try_psswrd),   32'd0);
    chk("rst_err",  32'(kp.entry_err),    32'd0);
    chk("rst_cnt",  32'(kp.digit_cnt),    32'd0);
    chk("rst_busy", 32'(kp.busy),         32'd0);
    rst = 1'b0;

    // 8, 7, ENTER -> 87, then holdoff with an ignored ENTER
    step(1'b1, 4'd8);
    chk("t1_cnt1",  32'(kp.digit_cnt), 32'd1);
    chk("t1_busy1", 32'(kp.busy),      32'd1);
    step(1'b1, 4'd7);
    chk("t1_cnt2",  32'(kp.digit_cnt), 32'd2);
    step(1'b1, KEY_ENTER);
    chk("t1_try",   32'(kp.try_psswrd),   32'd1);
    chk("t1_pin",   32'(kp.psswrd_atmpt), 32'h57);
    chk("t1_err",   32'(kp.entry_err),    32'd0);
    chk("t1_cnt0",  32'(kp.digit_cnt),    32'd0);
    chk("t1_ho1",   32'(kp.busy),         32'd1);
    step(1'b0, 4'h0);
    chk("t1_try_end", 32'(kp.try_psswrd), 32'd0);
    chk("t1_ho2",   32'(kp.busy),         32'd1);
    step(1'b0, 4'h0);
    chk("t1_ho3",   32'(kp.busy),         32'd1);
    step(1'b1, KEY_ENTER);
    chk("t1_ho_enter_try", 32'(kp.try_psswrd), 32'd0);
    chk("t1_ho4",   32'(kp.busy),         32'd1);
    step(1'b0, 4'h0);
    chk("t1_ho_done", 32'(kp.busy),       32'd0);

    // 3, 0, 0, ENTER -> overflow error, PIN kept
    step(1'b1, 4'd3);
    step(1'b1, 4'd0);
    step(1'b1, 4'd0);
    chk("t2_cnt3",  32'(kp.digit_cnt), 32'd3);
    step(1'b1, KEY_ENTER);
    chk("t2_err",   32'(kp.entry_err),    32'd1);
    chk("t2_try",   32'(kp.try_psswrd),   32'd0);
    chk("t2_pin",   32'(kp.psswrd_atmpt), 32'h57);
    idle(4);
    chk("t2_err_end", 32'(kp.entry_err), 32'd0);

    // 1, 2, 3, 4, ENTER -> 123, 4th digit dropped
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    step(1'b1, 4'd3);
    step(1'b1, 4'd4);
    chk("t2_drop_cnt", 32'(kp.digit_cnt), 32'd3);
    chk("t2_drop_err", 32'(kp.entry_err), 32'd0);
    step(1'b1, KEY_ENTER);
    chk("t2_try123", 32'(kp.try_psswrd),   32'd1);
    chk("t2_pin123", 32'(kp.psswrd_atmpt), 32'd123);
    idle(4);

    // 5, CLEAR, 9, ENTER -> 9; ENTER alone in IDLE does nothing
    step(1'b1, 4'd5);
    step(1'b1, KEY_CLEAR);
    chk("t3_clr_cnt",  32'(kp.digit_cnt), 32'd0);
    chk("t3_clr_busy", 32'(kp.busy),      32'd0);
    step(1'b1, 4'hC);
    chk("t3_ign_cnt",  32'(kp.digit_cnt), 32'd0);
    step(1'b1, 4'd9);
    step(1'b1, KEY_ENTER);
    chk("t3_try", 32'(kp.try_psswrd),   32'd1);
    chk("t3_pin", 32'(kp.psswrd_atmpt), 32'd9);
    idle(4);
    step(1'b1, KEY_ENTER);
    chk("t3_idle_enter_try",  32'(kp.try_psswrd), 32'd0);
    chk("t3_idle_enter_err",  32'(kp.entry_err),  32'd0);
    chk("t3_idle_enter_busy", 32'(kp.busy),       32'd0);

    // Key 4 then 1000 silent cycles -> timeout error
    step(1'b1, 4'd4);
    for (int i = 1; i <= 1000; i++) begin
      step(1'b0, 4'h0);
      if (i == 999) begin
        chk("t4_pre_err", 32'(kp.entry_err), 32'd0);
        chk("t4_pre_cnt", 32'(kp.digit_cnt), 32'd1);
      end
    end
    chk("t4_to_err",  32'(kp.entry_err), 32'd1);
    chk("t4_to_cnt",  32'(kp.digit_cnt), 32'd0);
    chk("t4_to_busy", 32'(kp.busy),      32'd0);
    step(1'b0, 4'h0);
    chk("t4_err_end", 32'(kp.entry_err), 32'd0);

    // Key on the expiry cycle wins
    step(1'b1, 4'd4);
    idle(999);
    step(1'b1, 4'd5);
    chk("t4_race_err", 32'(kp.entry_err), 32'd0);
    chk("t4_race_cnt", 32'(kp.digit_cnt), 32'd2);
    step(1'b0, 4'h0);
    chk("t4_race_err2", 32'(kp.entry_err), 32'd0);
    step(1'b1, KEY_CLEAR);

    // 8, en low, 7, ENTER -> 7
    step(1'b1, 4'd8);
    kp.en = 1'b0;
    step(1'b0, 4'h0);
    chk("t5_en_cnt",  32'(kp.digit_cnt), 32'd0);
    chk("t5_en_busy", 32'(kp.busy),      32'd0);
    kp.en = 1'b1;
    step(1'b1, 4'd7);
    step(1'b1, KEY_ENTER);
    chk("t5_try", 32'(kp.try_psswrd),   32'd1);
    chk("t5_pin", 32'(kp.psswrd_atmpt), 32'd7);
    idle(4);
    // en low together with ENTER: no pulse
    step(1'b1, 4'd5);
    kp.en = 1'b0;
    step(1'b1, KEY_ENTER);
    chk("t5_en_enter_try", 32'(kp.try_psswrd),   32'd0);
    chk("t5_en_enter_cnt", 32'(kp.digit_cnt),    32'd0);
    chk("t5_en_enter_pin", 32'(kp.psswrd_atmpt), 32'd7);
    kp.en = 1'b1;
    step(1'b0, 4'h0);

    // Reset mid-entry, then a normal submission
    step(1'b1, 4'd8);
    step(1'b1, 4'd7);
    rst = 1'b1;
    step(1'b0, 4'h0);
    chk("t6_rst_pin",  32'(kp.psswrd_atmpt), 32'h00);
    chk("t6_rst_cnt",  32'(kp.digit_cnt),    32'd0);
    chk("t6_rst_busy", 32'(kp.busy),         32'd0);
    chk("t6_rst_try",  32'(kp.try_psswrd),   32'd0);
    rst = 1'b0;
    step(1'b1, 4'd8);
    step(1'b1, 4'd7);
    step(1'b1, KEY_ENTER);
    chk("t6_try", 32'(kp.try_psswrd),   32'd1);
    chk("t6_pin", 32'(kp.psswrd_atmpt), 32'h57);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
